// File: rtl/bit_serial_addsub_pkg.sv
// Shared state encoding and width limits for the bit-serial adder/subtractor.
package bit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/bit_serial_addsub_fa.sv
// One-bit full adder slice used as the serial datapath.
module single_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cy_in,
  output logic sum,
  output logic cy_out
);

  assign sum    = a ^ b ^ cy_in;
  assign cy_out = (a & b) | (cy_in & (a ^ b));

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial add/sub, LSB first, one bit per clock with start/busy/done handshake.
module bit_serial_addsub
  import bit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cy_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("bit_serial_addsub: WIDTH out of range");
  end

  state_e           state;
  logic [WIDTH-1:0] sh_a, sh_b, sh_r;
  logic [CNT_W-1:0] cnt;
  logic             carry, sub_q;
  logic             fa_s, fa_co, last, cin_msb;
  logic [WIDTH-1:0] res_next;

  assign last     = (cnt == CNT_W'(WIDTH - 1));
  // On the final bit the registered carry is the carry into the MSB slice.
  assign cin_msb  = carry;
  assign res_next = {fa_s, sh_r[WIDTH-1:1]};

  single_bit_full_adder u_fa (
    .a      (sh_a[0]),
    .b      (sh_b[0]),
    .cy_in  (carry),
    .sum    (fa_s),
    .cy_out (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cy_out <= 1'b0;
      ovf    <= 1'b0;
      sh_a   <= '0;
      sh_b   <= '0;
      sh_r   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtract is a + ~b + ~borrow_in; borrow-out is the inverted carry.
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            carry <= sub ? ~cy_in : cy_in;
            sub_q <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          sh_r  <= res_next;
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            sum    <= res_next;
            cy_out <= sub_q ^ fa_co;
            ovf    <= cin_msb ^ fa_co;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
